// File: rtl/coralnpu_cosim_retire_seq.sv
// Buffers retired instructions and feeds them one at a time to the cosim step driver.
// Optional retire back-pressure output is enabled by defining COSIM_RETIRE_STALL_EN.
module coralnpu_cosim_retire_seq #(
  parameter int NUM_RETIRE = 2,
  parameter int DEPTH      = 16
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [NUM_RETIRE-1:0]      retire_valid,
  input  logic [32*NUM_RETIRE-1:0]   retire_pc,
  input  logic [32*NUM_RETIRE-1:0]   retire_insn,
  output logic                       step_valid,
  input  logic                       step_ready,
  output logic [31:0]                step_pc,
  output logic [31:0]                step_insn,
  input  logic                       result_valid,
  input  logic                       result_ok,
  input  logic                       sim_halted,
  output logic [2:0]                 state,
  output logic [$clog2(DEPTH+1)-1:0] occupancy,
  output logic [31:0]                step_count,
  output logic [1:0]                 error_code
`ifdef COSIM_RETIRE_STALL_EN
  ,
  output logic                       retire_stall
`endif
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OCC_W = $clog2(DEPTH+1);
  localparam int CNT_W = OCC_W + 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ISSUE  = 3'd1,
    S_WAIT   = 3'd2,
    S_HALTED = 3'd3,
    S_ERROR  = 3'd4
  } state_t;

  state_t             cur;
  state_t             nxt;
  logic [31:0]        mem_pc   [DEPTH];
  logic [31:0]        mem_insn [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   lane_off;
  logic [PTR_W-1:0]   lane_slot [NUM_RETIRE];
  logic [OCC_W-1:0]   occ_q;
  logic [CNT_W-1:0]   num_valid;
  logic [CNT_W-1:0]   free_slots;
  logic [CNT_W-1:0]   occ_next;
  logic [31:0]        cnt_q;
  logic [1:0]         err_q;
  logic [1:0]         err_nxt;
  logic               accept;
  logic               deq;
  logic               overflow;
  logic               enq_ok;
  logic               cnt_inc;

  // Handshake: a step transfers on a rising edge where step_valid && step_ready;
  // step_valid, step_pc and step_insn hold steady until that edge.
  assign step_valid = (cur == S_ISSUE);
  assign step_pc    = step_valid ? mem_pc[rd_ptr]   : 32'd0;
  assign step_insn  = step_valid ? mem_insn[rd_ptr] : 32'd0;
  assign state      = cur;
  assign occupancy  = occ_q;
  assign step_count = cnt_q;
  assign error_code = err_q;

  // Compact valid lanes into consecutive slots starting at the write pointer.
  always_comb begin
    num_valid = '0;
    lane_off  = '0;
    for (int i = 0; i < NUM_RETIRE; i++) begin
      lane_slot[i] = wr_ptr + lane_off;
      if (retire_valid[i]) begin
        lane_off  = lane_off + PTR_W'(1);
        num_valid = num_valid + CNT_W'(1);
      end
    end
  end

  always_comb begin
    accept     = (cur != S_HALTED) && (cur != S_ERROR);
    deq        = (cur == S_ISSUE) && step_ready;
    free_slots = CNT_W'(DEPTH) - CNT_W'(occ_q) + CNT_W'(deq);
    overflow   = accept && (num_valid > free_slots);
    enq_ok     = accept && !overflow;
    occ_next   = CNT_W'(occ_q) + (enq_ok ? num_valid : CNT_W'(0)) - CNT_W'(deq);
  end

  always_comb begin
    nxt     = cur;
    err_nxt = err_q;
    cnt_inc = 1'b0;
    case (cur)
      S_IDLE: begin
        if (result_valid) begin
          nxt     = S_ERROR;
          err_nxt = 2'd3;
        end else if (sim_halted) begin
          nxt = S_HALTED;
        end else if (occ_q != '0) begin
          nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (result_valid) begin
          nxt     = S_ERROR;
          err_nxt = 2'd3;
        end else if (step_ready) begin
          nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (result_valid) begin
          if (!result_ok) begin
            nxt     = S_ERROR;
            err_nxt = 2'd1;
          end else begin
            cnt_inc = 1'b1;
            if (sim_halted)          nxt = S_HALTED;
            else if (occ_next != '0) nxt = S_ISSUE;
            else                     nxt = S_IDLE;
          end
        end
      end
      S_HALTED: nxt = S_HALTED;
      S_ERROR:  nxt = S_ERROR;
      default:  nxt = S_IDLE;
    endcase
    // Overflow wins over everything except an error already raised this cycle.
    if (overflow && (nxt != S_ERROR)) begin
      nxt     = S_ERROR;
      err_nxt = 2'd2;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cur    <= S_IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ_q  <= '0;
      cnt_q  <= '0;
      err_q  <= '0;
`ifdef COSIM_RETIRE_STALL_EN
      retire_stall <= 1'b0;
`endif
    end else begin
      cur    <= nxt;
      err_q  <= err_nxt;
      wr_ptr <= wr_ptr + (enq_ok ? PTR_W'(num_valid) : PTR_W'(0));
      rd_ptr <= rd_ptr + PTR_W'(deq);
      occ_q  <= occ_next[OCC_W-1:0];
      if (cnt_inc) cnt_q <= cnt_q + 32'd1;
`ifdef COSIM_RETIRE_STALL_EN
      retire_stall <= (CNT_W'(DEPTH) - occ_next) < CNT_W'(2*NUM_RETIRE);
`endif
    end
  end

  // Queue storage is not reset; occupancy alone defines which entries are live.
  always_ff @(posedge clock) begin
    for (int i = 0; i < NUM_RETIRE; i++) begin
      if (enq_ok && retire_valid[i]) begin
        mem_pc[lane_slot[i]]   <= retire_pc[32*i +: 32];
        mem_insn[lane_slot[i]] <= retire_insn[32*i +: 32];
      end
    end
  end

endmodule

// File: tb/tb_coralnpu_cosim_retire_seq.sv
// Directed bench for coralnpu_cosim_retire_seq with a transaction-level queue model
// checked every cycle plus hand-computed literal expectations.
module tb_coralnpu_cosim_retire_seq;

  logic        clock;
  logic        reset;
  logic [1:0]  retire_valid;
  logic [63:0] retire_pc;
  logic [63:0] retire_insn;
  logic        step_valid;
  logic        step_ready;
  logic [31:0] step_pc;
  logic [31:0] step_insn;
  logic        result_valid;
  logic        result_ok;
  logic        sim_halted;
  logic [2:0]  state;
  logic [4:0]  occupancy;
  logic [31:0] step_count;
  logic [1:0]  error_code;
`ifdef COSIM_RETIRE_STALL_EN
  logic        retire_stall;
`endif

  int total = 0;
  int bad   = 0;

  coralnpu_cosim_retire_seq #(.NUM_RETIRE(2), .DEPTH(16)) dut (
    .clock        (clock),
    .reset        (reset),
    .retire_valid (retire_valid),
    .retire_pc    (retire_pc),
    .retire_insn  (retire_insn),
    .step_valid   (step_valid),
    .step_ready   (step_ready),
    .step_pc      (step_pc),
    .step_insn    (step_insn),
    .result_valid (result_valid),
    .result_ok    (result_ok),
    .sim_halted   (sim_halted),
    .state        (state),
    .occupancy    (occupancy),
    .step_count   (step_count),
    .error_code   (error_code)
`ifdef COSIM_RETIRE_STALL_EN
    ,
    .retire_stall (retire_stall)
`endif
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard model ----------------
  logic [31:0] exp_q[$];
  logic [31:0] exp_insn_q[$];
  bit          m_outst;
  bit          m_frozen;
  logic [2:0]  m_term;
  logic [1:0]  m_err;
  int          m_ok;
  bit          m_hold;
  logic [31:0] m_hold_pc;

  always @(negedge clock) begin
    int nv;
    int free;
    bit hs;
    if (reset) begin
      exp_q.delete();
      exp_insn_q.delete();
      m_outst  = 0;
      m_frozen = 0;
      m_term   = 3'd0;
      m_err    = 2'd0;
      m_ok     = 0;
      m_hold   = 0;
    end else begin
      check("model_occupancy", 32'(occupancy), 32'(exp_q.size()));
      check("model_step_count", step_count, 32'(m_ok));
      check("model_error_code", 32'(error_code), 32'(m_err));
      if (m_frozen) begin
        check("model_terminal_state", 32'(state), 32'(m_term));
        check("model_no_step_when_terminal", 32'(step_valid), 32'd0);
      end else if (m_outst) begin
        check("model_wait_state", 32'(state), 32'd2);
        check("model_no_step_when_outstanding", 32'(step_valid), 32'd0);
      end
      if (step_valid)
        check("model_step_legal", 32'(!m_outst && !m_frozen && exp_q.size() > 0), 32'd1);
      if (m_hold && !m_frozen) begin
        check("model_step_valid_held", 32'(step_valid), 32'd1);
        check("model_step_pc_held", step_pc, m_hold_pc);
      end
      hs = step_valid && step_ready;
      if (hs) begin
        if (exp_q.size() == 0) begin
          check("model_step_from_empty", 32'd1, 32'd0);
        end else begin
          check("model_step_pc", step_pc, exp_q[0]);
          check("model_step_insn", step_insn, exp_insn_q[0]);
        end
      end
      m_hold    = step_valid && !step_ready;
      m_hold_pc = step_pc;
      if (!m_frozen) begin
        nv   = int'(retire_valid[0]) + int'(retire_valid[1]);
        free = 16 - exp_q.size() + (hs ? 1 : 0);
        if (result_valid) begin
          if (!m_outst) begin
            m_frozen = 1; m_term = 3'd4; m_err = 2'd3;
          end else if (!result_ok) begin
            m_frozen = 1; m_term = 3'd4; m_err = 2'd1;
          end else begin
            m_ok++;
            m_outst = 0;
            if (sim_halted) begin
              m_frozen = 1; m_term = 3'd3;
            end
          end
        end else if (sim_halted && !m_outst && exp_q.size() == 0) begin
          m_frozen = 1; m_term = 3'd3;
        end
        if (hs && exp_q.size() > 0) begin
          void'(exp_q.pop_front());
          void'(exp_insn_q.pop_front());
          m_outst = 1;
        end
        if (nv > free) begin
          if (!(m_frozen && m_term == 3'd4)) begin
            m_frozen = 1; m_term = 3'd4; m_err = 2'd2;
          end
        end else begin
          if (retire_valid[0]) begin
            exp_q.push_back(retire_pc[31:0]);
            exp_insn_q.push_back(retire_insn[31:0]);
          end
          if (retire_valid[1]) begin
            exp_q.push_back(retire_pc[63:32]);
            exp_insn_q.push_back(retire_insn[63:32]);
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_lanes(input logic [1:0] v, input logic [31:0] pc0, input logic [31:0] in0,
                             input logic [31:0] pc1, input logic [31:0] in1);
    retire_valid = v;
    retire_pc    = {pc1, pc0};
    retire_insn  = {in1, in0};
  endtask

  task automatic idle_lanes();
    retire_valid = 2'b00;
  endtask

  task automatic do_reset();
    reset        = 1'b1;
    retire_valid = 2'b00;
    retire_pc    = '0;
    retire_insn  = '0;
    step_ready   = 1'b1;
    result_valid = 1'b0;
    result_ok    = 1'b0;
    sim_halted   = 1'b0;
    cyc();
    cyc();
    reset = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_state"}, 32'(state), 32'd0);
    check({tag, "_occupancy"}, 32'(occupancy), 32'd0);
    check({tag, "_step_count"}, step_count, 32'd0);
    check({tag, "_error_code"}, 32'(error_code), 32'd0);
    check({tag, "_step_valid"}, 32'(step_valid), 32'd0);
    check({tag, "_step_pc"}, step_pc, 32'd0);
    check({tag, "_step_insn"}, step_insn, 32'd0);
  endtask

  task automatic wait_hs(output logic [31:0] pc);
    bit got;
    got = 0;
    pc  = '0;
    for (int k = 0; k < 40; k++) begin
      if (step_valid && step_ready) begin
        got = 1;
        pc  = step_pc;
        break;
      end
      cyc();
    end
    if (!got) begin
      total++;
      bad++;
      $display("FAIL handshake_timeout: no step accepted within 40 cycles at %0t", $time);
    end
  endtask

  task automatic complete_step(input logic ok, output logic [31:0] pc);
    wait_hs(pc);
    cyc();
    result_valid = 1'b1;
    result_ok    = ok;
    cyc();
    result_valid = 1'b0;
    result_ok    = 1'b0;
  endtask

  // ---------------- directed tests ----------------
  logic [1:0] pat [8] = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00, 2'b11, 2'b00};

  initial begin
    logic [31:0] pc_a;
    logic [31:0] pc_b;
    logic [31:0] seq;
    bit          hs_prev;
    bit          got;

    // Single retire timing.
    do_reset();
    check_reset_state("reset");
    drive_lanes(2'b01, 32'h80, 32'h00000013, 32'h0, 32'h0);
    cyc();
    idle_lanes();
    check("single_c1_occupancy", 32'(occupancy), 32'd1);
    check("single_c1_state", 32'(state), 32'd0);
    check("single_c1_step_valid", 32'(step_valid), 32'd0);
    cyc();
    check("single_c2_step_valid", 32'(step_valid), 32'd1);
    check("single_c2_step_pc", step_pc, 32'h80);
    check("single_c2_step_insn", step_insn, 32'h00000013);
    check("single_c2_state", 32'(state), 32'd1);
    cyc();
    check("single_c3_state", 32'(state), 32'd2);
    check("single_c3_occupancy", 32'(occupancy), 32'd0);
    result_valid = 1'b1;
    result_ok    = 1'b1;
    cyc();
    result_valid = 1'b0;
    result_ok    = 1'b0;
    check("single_c4_step_count", step_count, 32'd1);
    check("single_c4_state", 32'(state), 32'd0);

    // Two lanes in one cycle issue in lane order.
    do_reset();
    drive_lanes(2'b11, 32'h100, 32'hAAAA0001, 32'h104, 32'hBBBB0002);
    cyc();
    idle_lanes();
    check("pair_occupancy", 32'(occupancy), 32'd2);
    complete_step(1'b1, pc_a);
    complete_step(1'b1, pc_b);
    check("pair_first_pc", pc_a, 32'h100);
    check("pair_second_pc", pc_b, 32'h104);
    check("pair_step_count", step_count, 32'd2);

    // Back-pressure from the driver holds the request stable.
    do_reset();
    step_ready = 1'b0;
    drive_lanes(2'b01, 32'h200, 32'h11111111, 32'h0, 32'h0);
    cyc();
    idle_lanes();
    got = 0;
    for (int k = 0; k < 10; k++) begin
      if (step_valid) begin
        got = 1;
        break;
      end
      cyc();
    end
    check("stall_step_seen", 32'(got), 32'd1);
    for (int k = 0; k < 5; k++) begin
      check("stall_step_pc", step_pc, 32'h200);
      check("stall_step_insn", step_insn, 32'h11111111);
      check("stall_occupancy", 32'(occupancy), 32'd1);
      cyc();
    end
    step_ready = 1'b1;
    complete_step(1'b1, pc_a);
    check("stall_released_pc", pc_a, 32'h200);

    // Mismatch on the third step.
    do_reset();
    drive_lanes(2'b11, 32'h300, 32'h1, 32'h304, 32'h2);
    cyc();
    drive_lanes(2'b01, 32'h308, 32'h3, 32'h0, 32'h0);
    cyc();
    idle_lanes();
    complete_step(1'b1, pc_a);
    complete_step(1'b1, pc_a);
    complete_step(1'b0, pc_a);
    check("mismatch_third_pc", pc_a, 32'h308);
    check("mismatch_state", 32'(state), 32'd4);
    check("mismatch_error_code", 32'(error_code), 32'd1);
    check("mismatch_step_count", step_count, 32'd2);
    drive_lanes(2'b11, 32'h30C, 32'h4, 32'h310, 32'h5);
    cyc();
    cyc();
    idle_lanes();
    result_valid = 1'b1;
    result_ok    = 1'b1;
    cyc();
    result_valid = 1'b0;
    check("mismatch_retires_ignored", 32'(occupancy), 32'd0);
    check("mismatch_error_sticky", 32'(error_code), 32'd1);

    // Fill the queue while a step is outstanding, then overflow.
    do_reset();
    drive_lanes(2'b01, 32'h400, 32'h7, 32'h0, 32'h0);
    cyc();
    idle_lanes();
    wait_hs(pc_a);
    cyc();
    check("fill_wait_state", 32'(state), 32'd2);
    for (int k = 0; k < 8; k++) begin
      drive_lanes(2'b11, 32'h500 + 32'(8*k), 32'h100 + 32'(k), 32'h504 + 32'(8*k), 32'h200 + 32'(k));
      cyc();
`ifdef COSIM_RETIRE_STALL_EN
      check("fill_retire_stall", 32'(retire_stall), 32'((16 - 2*(k+1)) < 4));
`endif
    end
    idle_lanes();
    check("fill_occupancy_full", 32'(occupancy), 32'd16);
    check("fill_no_error", 32'(error_code), 32'd0);
    drive_lanes(2'b11, 32'h600, 32'h8, 32'h604, 32'h9);
    cyc();
    idle_lanes();
    check("overflow_error_code", 32'(error_code), 32'd2);
    check("overflow_state", 32'(state), 32'd4);
    check("overflow_occupancy", 32'(occupancy), 32'd16);
    result_valid = 1'b1;
    result_ok    = 1'b1;
    cyc();
    result_valid = 1'b0;
    result_ok    = 1'b0;
    check("overflow_sticky", 32'(error_code), 32'd2);
    check("overflow_no_count", step_count, 32'd0);

    // Reset in the middle of WAIT; a late result is unrequested.
    do_reset();
    drive_lanes(2'b01, 32'h700, 32'h5, 32'h0, 32'h0);
    cyc();
    idle_lanes();
    wait_hs(pc_a);
    cyc();
    do_reset();
    check_reset_state("midwait_reset");
    result_valid = 1'b1;
    result_ok    = 1'b1;
    cyc();
    result_valid = 1'b0;
    result_ok    = 1'b0;
    check("late_result_error", 32'(error_code), 32'd3);
    check("late_result_state", 32'(state), 32'd4);

    // Halt together with a passing result.
    do_reset();
    drive_lanes(2'b10, 32'h0, 32'h0, 32'h800, 32'h6);
    cyc();
    idle_lanes();
    wait_hs(pc_a);
    check("halt_lane1_pc", pc_a, 32'h800);
    cyc();
    result_valid = 1'b1;
    result_ok    = 1'b1;
    sim_halted   = 1'b1;
    cyc();
    result_valid = 1'b0;
    result_ok    = 1'b0;
    sim_halted   = 1'b0;
    check("halt_wait_state", 32'(state), 32'd3);
    check("halt_wait_count", step_count, 32'd1);

    // Halt while idle and empty, then reset clears everything.
    do_reset();
    sim_halted = 1'b1;
    cyc();
    sim_halted = 1'b0;
    check("halt_idle_state", 32'(state), 32'd3);
    drive_lanes(2'b11, 32'h900, 32'h1, 32'h904, 32'h2);
    cyc();
    idle_lanes();
    check("halt_discards", 32'(occupancy), 32'd0);
    check("halt_terminal", 32'(state), 32'd3);
    do_reset();
    check_reset_state("halt_reset");

    // Streaming: 32 retires through a 16-deep queue (pointers wrap twice),
    // with enqueue and dequeue overlapping.
    do_reset();
    seq     = 0;
    hs_prev = 0;
    for (int c = 0; c < 64; c++) begin
      retire_valid = pat[c % 8];
      if (pat[c % 8][0]) begin
        retire_pc[31:0]   = 32'h1000 + 4*seq;
        retire_insn[31:0] = 32'hC0DE0000 + seq;
        seq++;
      end
      if (pat[c % 8][1]) begin
        retire_pc[63:32]   = 32'h1000 + 4*seq;
        retire_insn[63:32] = 32'hC0DE0000 + seq;
        seq++;
      end
      result_valid = hs_prev;
      result_ok    = 1'b1;
      hs_prev      = step_valid && step_ready;
      cyc();
    end
    idle_lanes();
    for (int c = 0; c < 200; c++) begin
      if (step_count == 32'd32 && occupancy == 5'd0 && !hs_prev) break;
      result_valid = hs_prev;
      result_ok    = 1'b1;
      hs_prev      = step_valid && step_ready;
      cyc();
    end
    result_valid = 1'b0;
    result_ok    = 1'b0;
    check("stream_step_count", step_count, 32'd32);
    check("stream_error_code", 32'(error_code), 32'd0);
    check("stream_state_idle", 32'(state), 32'd0);

    cyc();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/coralnpu_cosim_retire_seq.md
CORALNPU_COSIM_RETIRE_SEQ -- requirements
Module: coralnpu_cosim_retire_seq

Interface
REQ-001 SHALL have parameter NUM_RETIRE, default 2, meaning retire lanes sampled per cycle (1..4).
REQ-002 SHALL have parameter DEPTH, default 16, meaning queue entries (power of 2, at least 2*NUM_RETIRE).
REQ-003 SHALL have port clock, input, 1, meaning the single clock; all logic is on the rising edge.
REQ-004 SHALL have port reset, input, 1, meaning synchronous, active-high reset.
REQ-005 SHALL have port retire_valid, input, NUM_RETIRE, meaning per-lane retire strobe from the DUT; lane 0 is oldest.
REQ-006 SHALL have port retire_pc, input, 32*NUM_RETIRE, meaning per-lane retired PC; lane i is bits [32i+31:32i].
REQ-007 SHALL have port retire_insn, input, 32*NUM_RETIRE, meaning per-lane retired instruction word.
REQ-008 SHALL have port step_valid, output, 1, meaning a step request is presented to the cosim driver.
REQ-009 SHALL have port step_ready, input, 1, meaning the driver accepts the request (it calls mpact_step).
REQ-010 SHALL have ports step_pc and step_insn, output, 32 each, meaning the head entry's PC and instruction.
REQ-011 SHALL have ports result_valid and result_ok, input, 1 each, meaning step completion and pass (PC/GPR compare matched).
REQ-012 SHALL have port sim_halted, input, 1, meaning mpact_is_halted() returned 1.
REQ-013 SHALL have port state, output, 3, meaning the FSM encoding: IDLE=0, ISSUE=1, WAIT=2, HALTED=3, ERROR=4.
REQ-014 SHALL have port occupancy, output, $clog2(DEPTH+1), meaning current queue entry count.
REQ-015 SHALL have port step_count, output, 32, meaning steps completed with result_ok=1; wraps from 0xFFFFFFFF to 0.
REQ-016 SHALL have port error_code, output, 2, meaning 0=none, 1=mismatch, 2=overflow, 3=result-without-request.

Function
REQ-017 SHALL enqueue valid lanes every cycle, compacted in ascending lane order, regardless of state except HALTED and ERROR, where retires are discarded.
REQ-018 SHALL update occupancy with this cycle's enqueue count minus dequeue count; simultaneous enqueue and dequeue are permitted.
REQ-019 SHALL make a retire visible on step_valid no earlier than the cycle after capture; entries cannot bypass the queue.
REQ-020 In IDLE, SHALL go to ISSUE when occupancy is greater than 0, otherwise remain in IDLE.
REQ-021 In ISSUE, SHALL hold step_valid=1 with stable step_pc and step_insn until step_ready=1; the handshake dequeues the head and moves to WAIT.
REQ-022 In WAIT, SHALL hold step_valid=0 and wait for result_valid; only one step is ever outstanding.
REQ-023 On result_valid with result_ok=1, SHALL increment step_count and go to ISSUE if occupancy is greater than 0 after this cycle's enqueue, otherwise to IDLE.
REQ-024 On result_valid with result_ok=0, SHALL go to ERROR with error_code=1.
REQ-025 On result_valid outside WAIT, SHALL go to ERROR with error_code=3.
REQ-026 On sim_halted=1 in IDLE or WAIT-with-result_ok, SHALL go to HALTED; halt takes priority over a pending ISSUE.
REQ-027 HALTED and ERROR SHALL be terminal until reset; the first error_code latched is sticky.
REQ-028 If the number of valid lanes exceeds DEPTH-occupancy+dequeue in a cycle, SHALL drop all lanes that cycle and go to ERROR with error_code=2 (without COSIM_RETIRE_STALL_EN).
REQ-029 Queue pointers SHALL wrap modulo DEPTH.

Reset
REQ-030 While reset=1 at a clock edge, SHALL set state=IDLE, occupancy=0, step_count=0, error_code=0, step_valid=0, step_pc=0, step_insn=0, and retire_stall=0 when present.
REQ-031 Reset mid-WAIT or mid-ISSUE SHALL discard the queue and outstanding step; any result_valid on the first post-reset cycle is error 3.

Configuration
REQ-032 With COSIM_RETIRE_STALL_EN defined, SHALL add output retire_stall, 1 bit, registered, asserted when DEPTH-occupancy is less than 2*NUM_RETIRE; overflow (REQ-028) remains a backstop.
REQ-033 Without COSIM_RETIRE_STALL_EN, the retire_stall port SHALL be absent and the DUT is never back-pressured.

Verification
REQ-034 Single retire, pc=0x80, insn=0x00000013, step_ready=1, result_ok=1 one cycle later -> step_valid in cycle 2 with pc=0x80, step_count=1, state=IDLE.
REQ-035 Both lanes valid in one cycle (pc 0x100, 0x104) -> steps issued in order 0x100 then 0x104, never both outstanding.
REQ-036 step_ready low for 5 cycles -> step_pc and step_insn stable throughout, occupancy unchanged.
REQ-037 result_ok=0 on third step -> state=ERROR, error_code=1, step_count=2, later retires ignored.
REQ-038 Fill 16 entries with WAIT stalled, then 2 more lanes -> error_code=2 (no macro), or retire_stall=1 once occupancy reaches 13 (macro defined).
REQ-039 sim_halted=1 while IDLE with occupancy=0 -> HALTED; reset -> IDLE, all counters 0.
